// File: rtl/tcl_egress_arbiter.sv
// tcl_egress_arbiter
// Drains the four tcl output FIFOs (P0..P3) with a round-robin arbiter and
// merges the words into one egress stream tagged with the source port.
// Keeps a saturating per-port delivered-word counter with a req/idx read port.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   init                  synchronous clear of counters and RR pointer
//   emptyP0..3            tcl FIFO empty flags (registered in tcl)
//   dataOutputP0..3       tcl FIFO read data, valid the cycle after a pop
//   popOutP0..3           FIFO pop strobes, one-hot or zero
//   ready_in              downstream accepts the egress word
//   valid_out, data_out,
//   port_out              egress word and its source port
//   req, idx              counter read request / select
//   counterOut,
//   counterValid          counter read data and its strobe
module tcl_egress_arbiter #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              emptyP0,
    input  logic              emptyP1,
    input  logic              emptyP2,
    input  logic              emptyP3,
    input  logic [DATA_W-1:0] dataOutputP0,
    input  logic [DATA_W-1:0] dataOutputP1,
    input  logic [DATA_W-1:0] dataOutputP2,
    input  logic [DATA_W-1:0] dataOutputP3,
    output logic              popOutP0,
    output logic              popOutP1,
    output logic              popOutP2,
    output logic              popOutP3,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        port_out,
    input  logic              req,
    input  logic [2:0]        idx,
    output logic [CNT_W-1:0]  counterOut,
    output logic              counterValid
);

    localparam int unsigned NPORT  = 4;
    localparam int unsigned PORT_W = 2;
    localparam int unsigned ENT_W  = PORT_W + DATA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NPORT-1:0]  w_empty;
    logic [DATA_W-1:0] w_din [NPORT];

    logic [NPORT-1:0]  r_last_pop;
    logic              r_pend;
    logic [PORT_W-1:0] r_pend_port;
    logic [ENT_W-1:0]  r_buf0;
    logic [ENT_W-1:0]  r_buf1;
    logic [1:0]        r_occ;
    logic [PORT_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt [NPORT];
    logic [CNT_W-1:0]  r_cnt_out;
    logic              r_cnt_valid;

    logic [ENT_W-1:0]  w_in;
    logic [ENT_W-1:0]  w_head;
    logic [ENT_W-1:0]  w_second;
    logic [1:0]        w_eff;
    logic [1:0]        w_keep;
    logic              w_xfer;
    logic              w_room;
    logic [NPORT-1:0]  w_elig;
    logic [NPORT-1:0]  w_grant;
    logic              w_grant_vld;
    logic [PORT_W-1:0] w_grant_port;
    logic [PORT_W-1:0] w_cand;

    assign w_empty  = {emptyP3, emptyP2, emptyP1, emptyP0};
    assign w_din[0] = dataOutputP0;
    assign w_din[1] = dataOutputP1;
    assign w_din[2] = dataOutputP2;
    assign w_din[3] = dataOutputP3;

    // Buffer view: the word arriving from a pop issued last cycle counts as an
    // entry straight away, so an empty buffer presents it with no extra cycle.
    always_comb begin
        w_in     = {r_pend_port, w_din[r_pend_port]};
        w_eff    = r_occ + 2'(r_pend);
        w_head   = (r_occ == 2'd0 && r_pend) ? w_in : r_buf0;
        w_second = (r_occ == 2'd2) ? r_buf1 : w_in;
        w_xfer   = (w_eff != 2'd0) && ready_in;
        w_keep   = w_eff - 2'(w_xfer);
        w_room   = (w_keep != 2'd2);
    end

    // Round-robin grant; a port popped last cycle is skipped because its empty
    // flag has not caught up yet.
    always_comb begin
        w_elig       = '0;
        w_grant      = '0;
        w_grant_vld  = 1'b0;
        w_grant_port = '0;
        w_cand       = '0;
        if (!reset && w_room) begin
            w_elig = ~w_empty & ~r_last_pop;
        end
        // Scan downward so the lowest offset from the pointer is assigned last.
        for (int k = int'(NPORT) - 1; k >= 0; k--) begin
            w_cand = r_rr_ptr + PORT_W'(k);
            if (w_elig[w_cand]) begin
                w_grant_vld  = 1'b1;
                w_grant_port = w_cand;
            end
        end
        if (w_grant_vld) begin
            w_grant[w_grant_port] = 1'b1;
        end
    end

    // Pop tracking, RR pointer, skid buffer, counters and counter read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_pop  <= '0;
            r_pend      <= 1'b0;
            r_pend_port <= '0;
            r_buf0      <= '0;
            r_buf1      <= '0;
            r_occ       <= '0;
            r_rr_ptr    <= '0;
            r_cnt_out   <= '0;
            r_cnt_valid <= 1'b0;
            for (int i = 0; i < int'(NPORT); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_last_pop  <= w_grant;
            r_pend      <= w_grant_vld;
            r_pend_port <= w_grant_port;

            if (init) begin
                r_rr_ptr <= '0;
            end else if (w_grant_vld) begin
                r_rr_ptr <= w_grant_port + PORT_W'(1);
            end

            r_occ <= w_keep;
            if (w_keep != 2'd0) begin
                r_buf0 <= w_xfer ? w_second : w_head;
            end
            if (w_keep == 2'd2) begin
                r_buf1 <= w_second;
            end

            for (int i = 0; i < int'(NPORT); i++) begin
                if (init) begin
                    r_cnt[i] <= '0;
                end else if (w_xfer && (w_head[ENT_W-1 -: PORT_W] == PORT_W'(i))
                             && (r_cnt[i] != CNT_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

            if (req) begin
                r_cnt_valid <= 1'b1;
                r_cnt_out   <= idx[2] ? '0 : r_cnt[idx[1:0]];
            end else begin
                r_cnt_valid <= 1'b0;
            end
        end
    end

    assign popOutP0     = w_grant[0];
    assign popOutP1     = w_grant[1];
    assign popOutP2     = w_grant[2];
    assign popOutP3     = w_grant[3];
    assign valid_out    = (w_eff != 2'd0);
    assign data_out     = w_head[DATA_W-1:0];
    assign port_out     = w_head[ENT_W-1 -: PORT_W];
    assign counterOut   = r_cnt_out;
    assign counterValid = r_cnt_valid;

endmodule
